// File: rtl/w_io_reg.sv
// Configurable IO register block: per-channel input conditioning (bypass/reg/sync/edge) and
// optionally registered output path, configured through a single frame strobe.
module w_io_reg #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned CH_WIDTH        = 8,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 32,
  parameter int unsigned CFG_FRAME       = 0
) (
  input  logic                         UserCLK,
  input  logic                         UserRST,
  input  logic [FrameBitsPerRow-1:0]   FrameData,
  input  logic [MaxFramesPerCol-1:0]   FrameStrobe,
  output logic [FrameBitsPerRow-1:0]   FrameData_O,
  output logic [MaxFramesPerCol-1:0]   FrameStrobe_O,
  output logic                         UserCLKo,
  input  logic [NUM_CH*CH_WIDTH-1:0]   pad_in,
  output logic [NUM_CH*CH_WIDTH-1:0]   to_fabric,
  input  logic [NUM_CH*CH_WIDTH-1:0]   from_fabric,
  input  logic [NUM_CH-1:0]            fabric_oe,
  output logic [NUM_CH*CH_WIDTH-1:0]   pad_out,
  output logic [NUM_CH-1:0]            pad_oe,
  output logic                         cfg_valid
);

  localparam int unsigned DataW = NUM_CH * CH_WIDTH;
  localparam int unsigned CfgW  = NUM_CH * 4;

  if (CfgW > FrameBitsPerRow) begin : g_chk_width
    $error("w_io_reg: NUM_CH*4 exceeds FrameBitsPerRow");
  end
  if (CFG_FRAME >= MaxFramesPerCol) begin : g_chk_frame
    $error("w_io_reg: CFG_FRAME out of range");
  end

  assign FrameData_O   = FrameData;
  assign FrameStrobe_O = FrameStrobe;
  assign UserCLKo      = UserCLK;

  logic             strobe_q;
  logic             cfg_wr;
  logic [CfgW-1:0]  cfg_q;
  logic             cfg_valid_q;
  logic [DataW-1:0] s1_q, s2_q, s3_q;
  logic [DataW-1:0] pad_out_d, pad_out_q;
  logic [NUM_CH-1:0] pad_oe_d, pad_oe_q;

  assign cfg_wr    = FrameStrobe[CFG_FRAME] & ~strobe_q;
  assign cfg_valid = cfg_valid_q;

  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      strobe_q    <= 1'b0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      pad_out_q   <= '0;
      pad_oe_q    <= '0;
    end else begin
      strobe_q  <= FrameStrobe[CFG_FRAME];
      s1_q      <= pad_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
      if (cfg_wr) begin
        cfg_q       <= FrameData[CfgW-1:0];
        cfg_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    to_fabric = '0;
    pad_out_d = '0;
    pad_oe_d  = '0;
    pad_out   = '0;
    pad_oe    = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      logic [1:0] imode;
      logic       oreg;
      logic       oe_en;
      imode = cfg_q[4*ch +: 2];
      oreg  = cfg_q[4*ch + 2];
      oe_en = cfg_q[4*ch + 3];
      unique case (imode)
        2'b00: to_fabric[ch*CH_WIDTH +: CH_WIDTH] = pad_in[ch*CH_WIDTH +: CH_WIDTH];
        2'b01: to_fabric[ch*CH_WIDTH +: CH_WIDTH] = s1_q[ch*CH_WIDTH +: CH_WIDTH];
        2'b10: to_fabric[ch*CH_WIDTH +: CH_WIDTH] = s2_q[ch*CH_WIDTH +: CH_WIDTH];
        2'b11: to_fabric[ch*CH_WIDTH +: CH_WIDTH] =
                 s2_q[ch*CH_WIDTH +: CH_WIDTH] & ~s3_q[ch*CH_WIDTH +: CH_WIDTH];
        default: to_fabric[ch*CH_WIDTH +: CH_WIDTH] = '0;
      endcase
      pad_out_d[ch*CH_WIDTH +: CH_WIDTH] = from_fabric[ch*CH_WIDTH +: CH_WIDTH];
      pad_oe_d[ch] = oe_en & fabric_oe[ch];
      // Registered path keeps data and enable aligned on the same flop stage.
      pad_out[ch*CH_WIDTH +: CH_WIDTH] = oreg ? pad_out_q[ch*CH_WIDTH +: CH_WIDTH]
                                              : pad_out_d[ch*CH_WIDTH +: CH_WIDTH];
      pad_oe[ch] = oreg ? pad_oe_q[ch] : pad_oe_d[ch];
    end
  end

endmodule

// File: doc/w_io_reg.md
W_IO_REG -- requirements
Module: w_io_reg

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent IO channels.
REQ-002 Parameter CH_WIDTH, default 8: bits per channel.
REQ-003 Parameter FrameBitsPerRow, default 32: frame data width.
REQ-004 Parameter MaxFramesPerCol, default 32: frame strobe width.
REQ-005 Parameter CFG_FRAME, default 0: index of the FrameStrobe bit that writes this block's configuration.
REQ-006 UserCLK  in  1  sole clock; every flop is rising-edge UserCLK.
REQ-007 UserRST  in  1  synchronous active-high reset.
REQ-008 FrameData  in  FrameBitsPerRow  configuration frame data.
REQ-009 FrameStrobe  in  MaxFramesPerCol  frame write strobes.
REQ-010 FrameData_O  out  FrameBitsPerRow  buffered FrameData pass-through.
REQ-011 FrameStrobe_O  out  MaxFramesPerCol  buffered FrameStrobe pass-through.
REQ-012 UserCLKo  out  1  buffered UserCLK.
REQ-013 pad_in  in  NUM_CH*CH_WIDTH  external pad inputs.
REQ-014 to_fabric  out  NUM_CH*CH_WIDTH  conditioned pad data to fabric.
REQ-015 from_fabric  in  NUM_CH*CH_WIDTH  fabric data to pads.
REQ-016 fabric_oe  in  NUM_CH  per-channel output-enable request from fabric.
REQ-017 pad_out  out  NUM_CH*CH_WIDTH  data driven to pads.
REQ-018 pad_oe  out  NUM_CH  per-channel pad output enable.
REQ-019 cfg_valid  out  1  high once a configuration frame has been accepted since reset.

Function
REQ-020 The design SHALL fail elaboration if NUM_CH*4 > FrameBitsPerRow or CFG_FRAME >= MaxFramesPerCol.
REQ-021 The per-channel config field is cfg[ch] = FrameData[4*ch+3 : 4*ch]: bits[1:0] imode, bit[2] oreg, bit[3] oe_en.
REQ-022 Config write: a 1-flop history of FrameStrobe[CFG_FRAME] SHALL detect its rising edge; on that edge cycle all cfg fields are loaded from the FrameData present in the same cycle and cfg_valid is set; a strobe held high SHALL NOT reload.
REQ-023 Per channel, three input flops run every cycle regardless of mode: s1 <= pad_in, s2 <= s1, s3 <= s2.
REQ-024 imode 00 bypass: to_fabric = pad_in, combinational, 0 latency.
REQ-025 imode 01 registered: to_fabric = s1, 1 cycle latency.
REQ-026 imode 10 sync: to_fabric = s2, 2 cycle latency.
REQ-027 imode 11 edge: to_fabric = s2 & ~s3 per bit, a one-cycle pulse on each 0->1 transition, 2 cycles after the pad edge; a held-high input yields exactly one pulse.
REQ-028 oreg=0: pad_out = from_fabric and pad_oe[ch] = oe_en & fabric_oe[ch], both combinational.
REQ-029 oreg=1: pad_out and pad_oe[ch] are taken from flops capturing the REQ-028 values, 1 cycle latency, data and enable aligned.
REQ-030 Config change mid-stream: the new mode takes effect the cycle after the write edge; the pipeline flops are not flushed, so the first outputs reflect pipeline contents.
REQ-031 Channels SHALL be fully independent; config and data of one channel never affect another.
REQ-032 FrameData_O, FrameStrobe_O and UserCLKo are combinational buffers, unaffected by UserRST.

Reset
REQ-033 When UserRST=1 at a clock edge: all cfg fields, s1/s2/s3, output flops, strobe history and cfg_valid clear to 0.
REQ-034 After reset: imode bypass, oreg=0, oe_en=0, so pad_oe=0, to_fabric=pad_in, pad_out=from_fabric.
REQ-035 UserRST takes priority over a simultaneous config write edge; the write is lost and the strobe history clears, so a strobe still high after reset release IS seen as a rising edge.

Verification
REQ-036 Reset, then FrameStrobe[0] 0->1 with FrameData=0x0000_C6A1 -> next cycle cfg_valid=1; ch0 imode 01, ch1 imode 10 + oe_en, ch2 imode 10 + oreg, ch3 imode 00 + oreg + oe_en.
REQ-037 ch1 sync mode, pad_in ch1 0x00 -> 0x5A at cycle N -> to_fabric ch1 = 0x5A from cycle N+2; pad_oe[1] follows fabric_oe[1] combinationally.
REQ-038 ch0 set to imode 11, pad_in ch0 0x00 -> 0xFF held 5 cycles -> to_fabric ch0 = 0xFF for exactly one cycle (N+2), then 0x00.
REQ-039 ch3 oreg+oe_en, from_fabric ch3=0x3C, fabric_oe[3]=1 at cycle N -> pad_out ch3=0x3C and pad_oe[3]=1 both first at N+1.
REQ-040 Strobe held high 10 cycles while FrameData changes -> config equals FrameData of the first cycle only.
REQ-041 UserRST=1 coincident with a strobe rising edge, strobe held high after -> cycle after reset: cfg all 0, pad_oe=0; following cycle the held strobe loads config and cfg_valid=1.
